// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction-memory handshake, owns the PC,
// and fills the IF/ID register, using a one-entry skid buffer when decode stalls.
module instruction_fetch #(
    parameter logic [31:0] ResetVector = 32'h00000000
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Stall,
    input  logic        PCSource,
    input  logic [31:0] BranchTarget,
    output logic [31:0] InstructionAddress,
    output logic        InstructionRequest,
    input  logic        InstructionReady,
    input  logic [31:0] InstructionData,
    output logic [31:0] Instruction,
    output logic [5:0]  OperationCode,
    output logic [5:0]  Function,
    output logic [31:0] PCPlus4,
    output logic        InstructionValid
);

    typedef enum logic [1:0] {IDLE, REQUEST, DISCARD, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] plus4_q, plus4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_plus4_q, skid_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = BranchTarget & 32'hFFFF_FFFC;
    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQUEST;
            REQUEST: begin
                if (PCSource)
                    state_d = InstructionReady ? REQUEST : DISCARD;
                else if (InstructionReady && valid_q && Stall)
                    state_d = HOLD;
            end
            DISCARD: if (InstructionReady) state_d = REQUEST;
            HOLD:    if (PCSource || !Stall) state_d = REQUEST;
            default: state_d = IDLE;
        endcase
    end

    // While a redirected fetch drains, the old address must stay on the bus.
    always_comb begin
        InstructionRequest = (state_q == REQUEST) || (state_q == DISCARD);
        InstructionAddress = (state_q == DISCARD) ? hold_addr_q : pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        hold_addr_d  = hold_addr_q;
        instr_d      = instr_q;
        plus4_d      = plus4_q;
        skid_instr_d = skid_instr_q;
        skid_plus4_d = skid_plus4_q;
        valid_d      = valid_q;
        if (valid_q && !Stall) valid_d = 1'b0;
        case (state_q)
            REQUEST: begin
                if (PCSource) begin
                    pc_d        = target;
                    valid_d     = 1'b0;
                    hold_addr_d = pc_q;
                end else if (InstructionReady) begin
                    pc_d = pc_inc;
                    if (!valid_q || !Stall) begin
                        instr_d = InstructionData;
                        plus4_d = pc_inc;
                        valid_d = 1'b1;
                    end else begin
                        skid_instr_d = InstructionData;
                        skid_plus4_d = pc_inc;
                    end
                end
            end
            DISCARD: begin
                if (PCSource) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (PCSource) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d = skid_instr_q;
                    plus4_d = skid_plus4_q;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pc_q         <= ResetVector;
            hold_addr_q  <= 32'h0;
            instr_q      <= 32'h0;
            plus4_q      <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_plus4_q <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            hold_addr_q  <= hold_addr_d;
            instr_q      <= instr_d;
            plus4_q      <= plus4_d;
            skid_instr_q <= skid_instr_d;
            skid_plus4_q <= skid_plus4_d;
            valid_q      <= valid_d;
        end
    end

    assign Instruction      = instr_q;
    assign OperationCode    = instr_q[31:26];
    assign Function         = instr_q[5:0];
    assign PCPlus4          = plus4_q;
    assign InstructionValid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes the expected {instruction, PC+4}
// of every word decode will consume; a negedge monitor pops on each consumption.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Stall;
    logic        PCSource;
    logic [31:0] BranchTarget;
    logic [31:0] InstructionAddress;
    logic        InstructionRequest;
    logic        InstructionReady;
    logic [31:0] InstructionData;
    logic [31:0] Instruction;
    logic [5:0]  OperationCode;
    logic [5:0]  Function;
    logic [31:0] PCPlus4;
    logic        InstructionValid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    instruction_fetch #(.ResetVector(32'h00000000)) dut (
        .Clock(Clock), .ResetN(ResetN), .Stall(Stall), .PCSource(PCSource),
        .BranchTarget(BranchTarget), .InstructionAddress(InstructionAddress),
        .InstructionRequest(InstructionRequest), .InstructionReady(InstructionReady),
        .InstructionData(InstructionData), .Instruction(Instruction),
        .OperationCode(OperationCode), .Function(Function), .PCPlus4(PCPlus4),
        .InstructionValid(InstructionValid)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run 4ns after it.
    task automatic drive(input logic rdy, input logic [31:0] dat, input logic stl,
                         input logic ps, input logic [31:0] tgt);
        @(posedge Clock);
        #1;
        InstructionReady = rdy;
        InstructionData  = dat;
        Stall            = stl;
        PCSource         = ps;
        BranchTarget     = tgt;
        #3;
    endtask

    // Decode consumes the IF/ID word whenever it is valid and not stalled.
    always @(negedge Clock) begin
        if (ResetN === 1'b1 && InstructionValid === 1'b1 && Stall === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got instr %h pc4 %h expected no consumption",
                         Instruction, PCPlus4);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({Instruction, PCPlus4} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_consume: got instr %h pc4 %h expected instr %h pc4 %h",
                             Instruction, PCPlus4, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        ResetN = 1'b0; Stall = 1'b0; PCSource = 1'b0; BranchTarget = 32'h0;
        InstructionReady = 1'b0; InstructionData = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_valid", {31'b0, InstructionValid}, 32'h0);
        chk("rst_req", {31'b0, InstructionRequest}, 32'h0);
        chk("rst_pc4", PCPlus4, 32'h0);
        ResetN = 1'b1;
        #3;
        chk("idle_req", {31'b0, InstructionRequest}, 32'h0);

        // Back-to-back fetch from the reset vector
        drive(1, 32'h00000020, 0, 0, 0);
        exp_q.push_back({32'h00000020, 32'h4});
        chk("b2b_addr0", InstructionAddress, 32'h0);
        chk("b2b_req0", {31'b0, InstructionRequest}, 32'h1);
        drive(1, 32'h8C010004, 0, 0, 0);
        exp_q.push_back({32'h8C010004, 32'h8});
        chk("b2b_addr4", InstructionAddress, 32'h4);
        chk("b2b_op0", {26'b0, OperationCode}, 32'h00);
        chk("b2b_fn0", {26'b0, Function}, 32'h20);
        chk("b2b_pc4_0", PCPlus4, 32'h4);

        // Stall with a word returning: skid then HOLD
        drive(0, 32'h0, 1, 0, 0);
        chk("stl_addr8", InstructionAddress, 32'h8);
        chk("stl_op", {26'b0, OperationCode}, 32'h23);
        chk("stl_pc4", PCPlus4, 32'h8);
        drive(1, 32'h20420001, 1, 0, 0);
        exp_q.push_back({32'h20420001, 32'hC});
        drive(0, 32'h0, 1, 0, 0);
        chk("hold_req", {31'b0, InstructionRequest}, 32'h0);
        chk("hold_instr", Instruction, 32'h8C010004);
        chk("hold_valid", {31'b0, InstructionValid}, 32'h1);
        drive(0, 32'h0, 0, 0, 0);
        chk("hold_req2", {31'b0, InstructionRequest}, 32'h0);
        drive(1, 32'h00221820, 0, 0, 0);
        exp_q.push_back({32'h00221820, 32'h10});
        chk("unhold_instr", Instruction, 32'h20420001);
        chk("unhold_pc4", PCPlus4, 32'hC);
        chk("unhold_addr", InstructionAddress, 32'hC);

        // Redirect with request outstanding -> DISCARD
        drive(0, 32'h0, 0, 1, 32'h00000103);
        chk("dis_addr16", InstructionAddress, 32'h10);
        drive(0, 32'h0, 0, 0, 0);
        chk("dis_hold_addr", InstructionAddress, 32'h10);
        chk("dis_req", {31'b0, InstructionRequest}, 32'h1);
        chk("dis_valid", {31'b0, InstructionValid}, 32'h0);
        drive(1, 32'hDEADBEEF, 0, 0, 0);
        chk("dis_addr_still", InstructionAddress, 32'h10);
        drive(1, 32'h3C011234, 0, 0, 0);
        chk("redir_addr", InstructionAddress, 32'h100);
        chk("redir_valid", {31'b0, InstructionValid}, 32'h0);

        // Redirect together with Ready and Stall: word and IF/ID both flushed
        drive(1, 32'hCAFEF00D, 1, 1, 32'hFFFFFFFC);
        chk("flush_pre_instr", Instruction, 32'h3C011234);
        chk("flush_pre_pc4", PCPlus4, 32'h104);
        chk("flush_pre_addr", InstructionAddress, 32'h104);

        // Wraparound at the top of the address space
        drive(1, 32'h08000000, 0, 0, 0);
        exp_q.push_back({32'h08000000, 32'h0});
        chk("flush_valid", {31'b0, InstructionValid}, 32'h0);
        chk("flush_req", {31'b0, InstructionRequest}, 32'h1);
        chk("wrap_addr", InstructionAddress, 32'hFFFFFFFC);
        drive(0, 32'h0, 0, 0, 0);
        chk("wrap_pc4", PCPlus4, 32'h0);
        chk("wrap_next", InstructionAddress, 32'h0);

        // Reset while DISCARD drains; late Ready afterwards must be ignored
        drive(0, 32'h0, 0, 1, 32'h00000040);
        chk("consumed_valid", {31'b0, InstructionValid}, 32'h0);
        drive(0, 32'h0, 0, 0, 0);
        chk("dis2_req", {31'b0, InstructionRequest}, 32'h1);
        ResetN = 1'b0;
        InstructionReady = 1'b1;
        InstructionData = 32'hBAADF00D;
        @(negedge Clock);
        #1;
        chk("mrst_req", {31'b0, InstructionRequest}, 32'h0);
        chk("mrst_instr", Instruction, 32'h0);
        chk("mrst_pc4", PCPlus4, 32'h0);
        chk("mrst_addr", InstructionAddress, 32'h0);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        #3;
        chk("late_idle_req", {31'b0, InstructionRequest}, 32'h0);
        drive(1, 32'h24010001, 0, 0, 0);
        exp_q.push_back({32'h24010001, 32'h4});
        chk("late_valid", {31'b0, InstructionValid}, 32'h0);
        chk("post_rst_addr", InstructionAddress, 32'h0);
        chk("post_rst_req", {31'b0, InstructionRequest}, 32'h1);
        drive(0, 32'h0, 0, 0, 0);
        chk("post_rst_instr", Instruction, 32'h24010001);
        drive(0, 32'h0, 0, 0, 0);
        chk("sb_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: ResetVector, 32'h00000000, first fetch address after reset.
REQ-002 Ports: one clock; reset is asynchronous and active-low.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 ResetN  input  1  asynchronous active-low reset.
REQ-005 Stall  input  1  decode stage holds the IF/ID register.
REQ-006 PCSource  input  1  taken-branch redirect from the control decoder.
REQ-007 BranchTarget  input  32  redirect address; bits [1:0] forced to 0.
REQ-008 InstructionAddress  output  32  instruction-memory fetch address.
REQ-009 InstructionRequest  output  1  fetch request, held with a stable address until InstructionReady.
REQ-010 InstructionReady  input  1  memory returns InstructionData this cycle; ignored while InstructionRequest=0.
REQ-011 InstructionData  input  32  fetched word.
REQ-012 Instruction  output  32  IF/ID instruction register.
REQ-013 OperationCode  output  6  Instruction[31:26].
REQ-014 Function  output  6  Instruction[5:0].
REQ-015 PCPlus4  output  32  address of the IF/ID instruction plus 4.
REQ-016 InstructionValid  output  1  IF/ID register holds a live instruction.

Function
REQ-017 States: IDLE, REQUEST, DISCARD, HOLD; InstructionRequest=1 only in REQUEST and DISCARD (decoded from state).
REQ-018 IDLE: entered on reset; moves to REQUEST after one clock.
REQ-019 REQUEST: InstructionAddress=PC; on InstructionReady with (InstructionValid=0 or Stall=0) and PCSource=0: IF/ID <= InstructionData, PCPlus4 <= PC+4, InstructionValid <= 1, PC <= PC+4, stay REQUEST.
REQ-020 Back-to-back fetch: one instruction per cycle when InstructionReady is high every cycle.
REQ-021 REQUEST, InstructionReady, Stall=1, InstructionValid=1, PCSource=0: word and PC captured into a one-entry skid buffer; IF/ID unchanged; PC <= PC+4; go HOLD.
REQ-022 HOLD: no request; when Stall=0, skid moves into IF/ID (InstructionValid=1), go REQUEST; while Stall=1, stay HOLD.
REQ-023 Stall=0 with InstructionValid=1 and no new word: InstructionValid <= 0 (consumed); Stall=1 holds all IF/ID outputs.
REQ-024 PCSource=1 has priority over everything in any non-IDLE state: PC <= BranchTarget, InstructionValid <= 0, skid emptied, Stall ignored that cycle.
REQ-025 Redirect in REQUEST without InstructionReady: save current address in AddressHold, go DISCARD.
REQ-026 DISCARD: InstructionAddress=AddressHold, request held; on InstructionReady drop the data, go REQUEST with PC.
REQ-027 Redirect in REQUEST with InstructionReady, or in HOLD: data dropped, go REQUEST (next address = BranchTarget).
REQ-028 Redirect in DISCARD: PC updated; remain DISCARD unless InstructionReady, then REQUEST.
REQ-029 PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, no flag.

Reset
REQ-030 ResetN=0 asynchronously forces: state IDLE, PC=ResetVector, Instruction=0, PCPlus4=0, InstructionValid=0, skid empty, InstructionRequest=0.
REQ-031 Reset mid-handshake abandons the outstanding request; the late InstructionReady after reset (in IDLE) is ignored.
REQ-032 First request issues the cycle after IDLE, at ResetVector.

Verification
REQ-033 Release reset, InstructionReady=1 constant, data 32'h00000020, 32'h8C010004 -> addresses 0,4,8; OperationCode 6'h00/Function 6'h20, then OperationCode 6'h23; PCPlus4 4 then 8.
REQ-034 IF/ID valid, Stall=1 two cycles, word at address 8 returns -> HOLD, IF/ID unchanged, request low; Stall=0 -> address-8 word in IF/ID, PCPlus4=12, fetch resumes at 12.
REQ-035 Request to 16 outstanding, PCSource=1, BranchTarget=32'h00000103 -> DISCARD, address 16 held; InstructionReady -> data dropped, InstructionValid=0, next address 32'h00000100.
REQ-036 PCSource=1 same cycle as InstructionReady and Stall=1 -> InstructionValid=0, skid empty, next address BranchTarget.
REQ-037 PC=32'hFFFFFFFC fetched -> PCPlus4=0, next address 0.
REQ-038 ResetN low during DISCARD -> all outputs at reset values immediately; first request after release at ResetVector.
